icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Sequences line refills for the instruction cache.
- On a cache refill request it issues a wrapping, critical-word-first burst read on the instruction bus, and streams each returned word into the cache write port (write address, write data, write enable).
- Bus errors and a stalled bus are reported back to the cache as an imem error.
- Sits between the cache and the ibus bridge inside the fetch unit.

Parameters:
- OPTION_OPERAND_WIDTH, 32, address/data width.
- OPTION_ICACHE_BLOCK_WIDTH, 5, log2 of line size in bytes. Only 4 and 5 are legal (4 or 8 words per line).
- OPTION_IBUS_TIMEOUT, 255, cycles without ack/err before a timeout error. 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- refill_req_i  in  1  cache requests a refill (read miss).
- refill_i  in  1  cache is in its refill state.
- refill_done_i  in  1  cache has seen the final word of the line.
- cpu_adr_match_i  in  OPTION_OPERAND_WIDTH  missing fetch address.
- ibus_req_o  out  1  bus request.
- ibus_adr_o  out  OPTION_OPERAND_WIDTH  bus word address.
- ibus_burst_o  out  1  more beats follow the current one.
- ibus_ack_i  in  1  beat accepted, data valid.
- ibus_err_i  in  1  bus error.
- ibus_dat_i  in  OPTION_OPERAND_WIDTH  read data.
- wradr_o  out  OPTION_OPERAND_WIDTH  cache write address.
- wrdat_o  out  OPTION_OPERAND_WIDTH  cache write data.
- we_o  out  1  cache write strobe.
- imem_err_o  out  1  one-cycle error pulse to the cache.
- busy_o  out  1  controller not IDLE.

Behaviour:
- WORDS = 1 << (OPTION_ICACHE_BLOCK_WIDTH-2). Word offset field is adr[OPTION_ICACHE_BLOCK_WIDTH-1:2].
- States: IDLE, BURST, WAIT_DONE.

IDLE:
- All outputs 0.
- When refill_req_i = 1, register:
  - base = cpu_adr_match_i with bits [1:0] cleared;
  - offset = base word offset;
  - beat count = 0;
  - timeout counter = 0.
- Next state BURST. Bus request appears in the cycle after refill_req_i (1 cycle latency).

BURST:
- ibus_req_o = 1.
- ibus_adr_o = {base upper bits, offset, 2'b00}.
- ibus_burst_o = 1 while beat count < WORDS-1.
- we_o = ibus_ack_i (combinational, same cycle). wradr_o = ibus_adr_o. wrdat_o = ibus_dat_i.
- On each ack:
  - offset increments modulo WORDS, wrapping within the line; upper address bits never change;
  - beat count increments;
  - timeout counter clears.
- On the ack with beat count == WORDS-1: next state WAIT_DONE. ibus_req_o drops the following cycle.
- Cycles without ack or err increment the timeout counter.

WAIT_DONE:
- No bus activity.
- Exit to IDLE when refill_i == 0 or refill_done_i was seen.
- refill_done_i asserted during the last beat is also accepted and returns directly to IDLE.

Errors:
- ibus_err_i in BURST, or timeout counter reaching OPTION_IBUS_TIMEOUT (when nonzero):
  - imem_err_o = 1 for exactly one cycle, registered (the cycle after the err/timeout cycle);
  - no write strobe for that beat;
  - ibus_req_o drops next cycle;
  - state returns to IDLE. The cache discards the partial line itself.
- ack and err asserted together: err wins, no write.

Other rules:
- refill_req_i outside IDLE is ignored.
- busy_o = (state != IDLE).
- Reset in any state: next cycle state IDLE, all outputs 0, counters 0. No partial write completes after reset.
- wradr_o/wrdat_o are don't-care when we_o = 0. They are driven from ibus_adr_o/ibus_dat_i regardless.

Test Plan:
- BLOCK_WIDTH=5, miss at 0x0000_1014, ack every cycle → bus addresses 0x14, 0x18, 0x1C, 0x00, 0x04, 0x08, 0x0C, 0x10 (upper bits 0x1000). 8 we_o pulses with matching wradr_o. ibus_burst_o low only on the 8th beat. Then IDLE.
- Same miss with ack on alternate cycles → 8 writes over 16 cycles. Address only advances on ack. No timeout.
- ibus_err_i on beat 3 → exactly 2 writes. imem_err_o high 1 cycle. ibus_req_o low next cycle. State IDLE. A new refill_req_i is accepted afterwards.
- OPTION_IBUS_TIMEOUT=4, no ack after request → imem_err_o pulses 1 cycle, no we_o, back to IDLE.
- rst asserted mid-burst after beat 5 → next cycle ibus_req_o = 0, we_o = 0, busy_o = 0. Subsequent refill of 0x2000 starts at offset 0.
- BLOCK_WIDTH=4, miss at 0x0000_300C → bus addresses 0x300C, 0x3000, 0x3004, 0x3008. ack and err together on beat 2 → no write for that beat, error pulse.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: sequences instruction-cache line refills.
// A refill request starts a wrapping, critical-word-first burst read on the
// instruction bus. Each acknowledged beat is forwarded to the cache write port.
// A bus error or a bus timeout is reported to the cache as a one-cycle
// imem_err_o pulse.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   refill_req_i      cache read miss, start a refill (sampled in IDLE only)
//   refill_i          cache is in its refill state
//   refill_done_i     cache has seen the final word of the line
//   cpu_adr_match_i   missing fetch address
//   ibus_req_o        bus request
//   ibus_adr_o        bus word address
//   ibus_burst_o      more beats follow the current one
//   ibus_ack_i        beat accepted, read data valid
//   ibus_err_i        bus error
//   ibus_dat_i        bus read data
//   wradr_o, wrdat_o  cache write address / data
//   we_o              cache write strobe
//   imem_err_o        one-cycle error pulse to the cache
//   busy_o            controller not idle
module icache_refill_ctrl #(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5,
  parameter int OPTION_IBUS_TIMEOUT       = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            refill_req_i,
  input  logic                            refill_i,
  input  logic                            refill_done_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] cpu_adr_match_i,
  output logic                            ibus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
  output logic                            ibus_burst_o,
  input  logic                            ibus_ack_i,
  input  logic                            ibus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
  output logic                            we_o,
  output logic                            imem_err_o,
  output logic                            busy_o
);

  localparam int AW    = OPTION_OPERAND_WIDTH;
  localparam int BW    = OPTION_ICACHE_BLOCK_WIDTH;
  localparam int OW    = BW - 2;
  localparam int WORDS = 1 << OW;
  localparam int TW    = (OPTION_IBUS_TIMEOUT > 0) ? $clog2(OPTION_IBUS_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    WAIT_DONE
  } state_t;

  state_t           state_q;
  logic [AW-1:BW]   base_q;
  logic [OW-1:0]    off_q;
  logic [OW-1:0]    beat_q;
  logic [TW-1:0]    tmo_q;
  logic             err_q;

  logic             in_burst;
  logic             bus_err;
  logic             tmo_hit;
  logic             beat_ack;
  logic             last_beat;
  logic [OW-1:0]    off_d;
  logic [OW-1:0]    beat_d;
  logic [TW-1:0]    tmo_d;
  logic             unused_adr_lsbs;

  assign unused_adr_lsbs = ^cpu_adr_match_i[1:0];

  assign in_burst  = (state_q == BURST);
  assign bus_err   = in_burst & ibus_err_i;
  // ack and err together count as an error: the beat is not written.
  assign beat_ack  = in_burst & ibus_ack_i & ~ibus_err_i;
  assign last_beat = (beat_q == OW'(WORDS - 1));
  // Offset wraps within the line through natural overflow of the field.
  assign off_d     = off_q + 1'b1;
  assign beat_d    = beat_q + 1'b1;
  assign tmo_d     = tmo_q + 1'b1;
  // Fires on the cycle in which the count of silent bus cycles reaches the limit.
  assign tmo_hit   = (OPTION_IBUS_TIMEOUT != 0) && in_burst && !ibus_ack_i && !ibus_err_i &&
                     (tmo_d == TW'(OPTION_IBUS_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      off_q   <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (refill_req_i) begin
            base_q  <= cpu_adr_match_i[AW-1:BW];
            off_q   <= cpu_adr_match_i[BW-1:2];
            beat_q  <= '0;
            tmo_q   <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (bus_err || tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (beat_ack) begin
            off_q  <= off_d;
            beat_q <= beat_d;
            tmo_q  <= '0;
            if (last_beat) begin
              state_q <= refill_done_i ? IDLE : WAIT_DONE;
            end
          end else begin
            tmo_q <= tmo_d;
          end
        end
        WAIT_DONE: begin
          if (!refill_i || refill_done_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ibus_req_o   = in_burst;
  assign ibus_adr_o   = in_burst ? {base_q, off_q, 2'b00} : '0;
  assign ibus_burst_o = in_burst & ~last_beat;
  assign we_o         = beat_ack;
  assign wradr_o      = ibus_adr_o;
  assign wrdat_o      = in_burst ? ibus_dat_i : '0;
  assign imem_err_o   = err_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        refill_req  [2];
  logic        refill      [2];
  logic        refill_done [2];
  logic [31:0] cpu_adr     [2];
  logic        ibus_ack    [2];
  logic        ibus_err    [2];
  logic [31:0] ibus_dat    [2];
  logic        ibus_req    [2];
  logic [31:0] ibus_adr    [2];
  logic        ibus_burst  [2];
  logic [31:0] wradr       [2];
  logic [31:0] wrdat       [2];
  logic        we          [2];
  logic        imem_err    [2];
  logic        busy        [2];

  // Unit 0: 8-word lines, timeout 4. Unit 1: 4-word lines, timeout 6.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    icache_refill_ctrl #(
      .OPTION_OPERAND_WIDTH     (32),
      .OPTION_ICACHE_BLOCK_WIDTH((g == 0) ? 5 : 4),
      .OPTION_IBUS_TIMEOUT      ((g == 0) ? 4 : 6)
    ) dut (
      .clk            (clk),
      .rst            (rst),
      .refill_req_i   (refill_req[g]),
      .refill_i       (refill[g]),
      .refill_done_i  (refill_done[g]),
      .cpu_adr_match_i(cpu_adr[g]),
      .ibus_req_o     (ibus_req[g]),
      .ibus_adr_o     (ibus_adr[g]),
      .ibus_burst_o   (ibus_burst[g]),
      .ibus_ack_i     (ibus_ack[g]),
      .ibus_err_i     (ibus_err[g]),
      .ibus_dat_i     (ibus_dat[g]),
      .wradr_o        (wradr[g]),
      .wrdat_o        (wrdat[g]),
      .we_o           (we[g]),
      .imem_err_o     (imem_err[g]),
      .busy_o         (busy[g])
    );
  end

  function automatic int words(input int u);
    return (u == 0) ? 8 : 4;
  endfunction

  function automatic int tmo_lim(input int u);
    return (u == 0) ? 4 : 6;
  endfunction

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          u;
    int          c;
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  typedef struct {
    int u;
    int c;
  } er_t;

  wr_t wq[$];
  er_t eq[$];

  // Monitor: every write strobe or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    wr_t w;
    er_t e;
    for (int u = 0; u < 2; u++) begin
      if (we[u] === 1'b1) begin
        if (wq.size() == 0) begin
          chk($sformatf("unexpected_write_u%0d", u), 32'd1, 32'd0);
        end else begin
          w = wq.pop_front();
          chk("wr_unit", 32'(u), 32'(w.u));
          chk("wr_cycle", 32'(cyc), 32'(w.c));
          chk("wr_adr", wradr[u], w.adr);
          chk("wr_dat", wrdat[u], w.dat);
        end
      end
      if (imem_err[u] === 1'b1) begin
        if (eq.size() == 0) begin
          chk($sformatf("unexpected_imem_err_u%0d", u), 32'd1, 32'd0);
        end else begin
          e = eq.pop_front();
          chk("err_unit", 32'(u), 32'(e.u));
          chk("err_cycle", 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int u = 0; u < 2; u++) begin
      refill_req[u]  = 1'b0;
      refill[u]      = 1'b0;
      refill_done[u] = 1'b0;
      cpu_adr[u]     = '0;
      ibus_ack[u]    = 1'b0;
      ibus_err[u]    = 1'b0;
      ibus_dat[u]    = '0;
    end
  endtask

  task automatic chk_idle(input int u, input string tag);
    chk({tag, "_busy"}, 32'(busy[u]), 32'd0);
    chk({tag, "_req"}, 32'(ibus_req[u]), 32'd0);
    chk({tag, "_adr"}, ibus_adr[u], 32'd0);
  endtask

  // mode: 0 ack every cycle, 1 ack on alternate cycles, 2 random, 3 never respond.
  // err_beat: beat index that receives ibus_err (-1 none); both: ack with that err.
  // done_mode: 0 leave via refill_i low, 1 refill_done with last beat, 2 refill_done later.
  // rst_after: assert reset once this many beats have been written (-1 none).
  task automatic run_refill(input int u, input logic [31:0] miss, input int mode,
                            input int err_beat, input bit both, input int done_mode,
                            input int rst_after);
    int          w;
    int          off0;
    logic [31:0] upper;
    logic [31:0] exp_adr;
    int          beat;
    int          idle;
    int          c;
    bit          fin;
    bit          errd;
    bit          resp;
    wr_t         wi;
    er_t         ei;

    w     = words(u);
    off0  = int'((miss >> 2) % 32'(w));
    upper = miss & ~(32'(w * 4) - 32'd1);
    beat  = 0;
    idle  = 0;
    c     = 0;
    fin   = 1'b0;
    errd  = 1'b0;

    refill_req[u] = 1'b1;
    cpu_adr[u]    = miss;
    @(negedge clk);
    chk("req_cycle_busy", 32'(busy[u]), 32'd0);
    tick();
    refill_req[u] = 1'b0;
    cpu_adr[u]    = $urandom;
    refill[u]     = 1'b1;

    while (!fin) begin
      if (beat == rst_after) begin
        rst         = 1'b1;
        ibus_ack[u] = 1'b0;
        ibus_err[u] = 1'b0;
        tick();
        rst         = 1'b0;
        refill[u]   = 1'b0;
        ibus_ack[u] = 1'b1;
        ibus_dat[u] = $urandom;
        @(negedge clk);
        chk_idle(u, "after_rst");
        tick();
        clear_inputs();
        @(negedge clk);
        chk("rst_wq_empty", 32'(wq.size()), 32'd0);
        chk("rst_eq_empty", 32'(eq.size()), 32'd0);
        tick();
        return;
      end
      exp_adr = upper | 32'(((off0 + beat) % w) * 4);
      case (mode)
        0:       resp = 1'b1;
        1:       resp = (c % 2) == 1;
        2:       resp = ($urandom % 100) < 65;
        default: resp = 1'b0;
      endcase
      ibus_err[u]    = resp && (beat == err_beat);
      ibus_ack[u]    = resp && ((beat != err_beat) || both);
      ibus_dat[u]    = $urandom;
      refill_req[u]  = ($urandom % 4) == 0;
      refill_done[u] = (done_mode == 1) && (beat == w - 1);

      if (ibus_err[u]) begin
        ei.u = u; ei.c = cyc + 1; eq.push_back(ei);
        errd = 1'b1;
        fin  = 1'b1;
      end else if (ibus_ack[u]) begin
        wi.u = u; wi.c = cyc; wi.adr = exp_adr; wi.dat = ibus_dat[u];
        wq.push_back(wi);
        idle = 0;
      end else begin
        idle++;
        if (idle == tmo_lim(u)) begin
          ei.u = u; ei.c = cyc + 1; eq.push_back(ei);
          errd = 1'b1;
          fin  = 1'b1;
        end
      end

      @(negedge clk);
      chk("burst_busy", 32'(busy[u]), 32'd1);
      chk("burst_req", 32'(ibus_req[u]), 32'd1);
      chk("burst_adr", ibus_adr[u], exp_adr);
      chk("burst_more", 32'(ibus_burst[u]), 32'(beat < w - 1));

      if (!errd && ibus_ack[u]) begin
        beat++;
        if (beat == w) fin = 1'b1;
      end
      c++;
      tick();
    end

    ibus_err[u]    = 1'b0;
    refill_done[u] = 1'b0;
    ibus_ack[u]    = 1'b1;
    ibus_dat[u]    = $urandom;
    refill_req[u]  = 1'b0;

    if (errd || done_mode == 1) begin
      refill[u] = 1'b0;
      @(negedge clk);
      chk_idle(u, errd ? "after_err" : "after_done");
      tick();
    end else begin
      for (int k = 0; k < 3; k++) begin
        refill_req[u] = 1'b1;
        if (k == 2) begin
          if (done_mode == 2) refill_done[u] = 1'b1;
          else                refill[u]      = 1'b0;
        end
        @(negedge clk);
        chk("wait_busy", 32'(busy[u]), 32'd1);
        chk("wait_req", 32'(ibus_req[u]), 32'd0);
        tick();
      end
      refill_req[u]  = 1'b0;
      refill_done[u] = 1'b0;
      refill[u]      = 1'b0;
      @(negedge clk);
      chk_idle(u, "after_wait");
      tick();
    end

    clear_inputs();
    @(negedge clk);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("eq_empty", 32'(eq.size()), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    for (int u = 0; u < 2; u++) ibus_ack[u] = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk_idle(u, "reset");
      chk("reset_burst", 32'(ibus_burst[u]), 32'd0);
      chk("reset_we", 32'(we[u]), 32'd0);
      chk("reset_imem_err", 32'(imem_err[u]), 32'd0);
      chk("reset_wrdat", wrdat[u], 32'd0);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();

    // 8-word line, critical word first from 0x1014.
    run_refill(0, 32'h0000_1014, 0, -1, 1'b0, 0, -1);
    run_refill(0, 32'h0000_1014, 1, -1, 1'b0, 2, -1);
    // Error on the third beat, then a fresh refill is accepted.
    run_refill(0, 32'h0000_1014, 0, 2, 1'b0, 0, -1);
    run_refill(0, 32'h0000_1014, 0, -1, 1'b0, 1, -1);
    // Silent bus: timeout.
    run_refill(0, 32'h0000_4000, 3, -1, 1'b0, 0, -1);
    // Reset after five beats, then a refill of 0x2000 starts at offset 0.
    run_refill(0, 32'h0000_1014, 0, -1, 1'b0, 0, 5);
    run_refill(0, 32'h0000_2000, 0, -1, 1'b0, 1, -1);
    // 4-word line from 0x300C, then ack+err together on the second beat.
    run_refill(1, 32'h0000_300C, 0, -1, 1'b0, 0, -1);
    run_refill(1, 32'h0000_300C, 0, 1, 1'b1, 0, -1);
    run_refill(1, 32'h0000_5008, 3, -1, 1'b0, 0, -1);

    for (int i = 0; i < 24; i++) begin
      int u;
      int eb;
      u  = i % 2;
      eb = (($urandom % 4) == 0) ? int'($urandom % 32'(words(u))) : -1;
      run_refill(u, $urandom, 2, eb, 1'(($urandom % 2)), int'($urandom % 3), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
